// File: rtl/nibble_serializer.sv
// Byte-to-nibble serializer: buffers producer bytes in a circular queue and emits
// low/high nibbles per byte. Optional checksum nibble per frame via SER_CHECKSUM_EN.
module nibble_serializer #(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     byte_in,
  input  logic                           byte_valid,
  output logic                           byte_ready,
  output logic [3:0]                     nib_out,
  output logic                           nib_valid,
  input  logic                           nib_ready,
  output logic [$clog2(BUF_DEPTH):0]     level
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || FRAME_LEN < 1) begin : g_bad_param
    $error("nibble_serializer: BUF_DEPTH must be a power of two >= 2 and FRAME_LEN >= 1");
  end

`ifdef SER_CHECKSUM_EN
  typedef enum logic [1:0] {PH_LO, PH_HI, PH_CK} phase_t;
  localparam int unsigned FC_W = $clog2(FRAME_LEN + 1);
  logic [3:0]      checksum;
  logic [FC_W-1:0] frame_cnt;
  logic            frame_last;
`else
  typedef enum logic {PH_LO, PH_HI} phase_t;
`endif

  phase_t             phase, phase_nxt;
  logic [7:0]         mem [BUF_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [7:0]         head;
  logic               has_data;
  logic               push, xfer, pop;

  assign head       = mem[rd_ptr];
  assign has_data   = (count != '0);
  assign byte_ready = ~rst & (count < CNT_W'(BUF_DEPTH));
  assign level      = count;
  assign push       = byte_valid & byte_ready;
  assign xfer       = nib_valid & nib_ready;
  assign pop        = xfer & (phase == PH_HI);

`ifdef SER_CHECKSUM_EN
  assign frame_last = (frame_cnt == FC_W'(FRAME_LEN - 1));
`endif

  // Phase state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) phase <= PH_LO;
    else     phase <= phase_nxt;
  end

  // Next phase and nibble output
  always_comb begin
    phase_nxt = phase;
    nib_valid = 1'b0;
    nib_out   = 4'h0;
    case (phase)
      PH_LO: begin
        nib_valid = has_data;
        if (has_data) begin
          nib_out = head[3:0];
          if (nib_ready) phase_nxt = PH_HI;
        end
      end
      PH_HI: begin
        nib_valid = has_data;
        if (has_data) begin
          nib_out = head[7:4];
`ifdef SER_CHECKSUM_EN
          if (nib_ready) phase_nxt = frame_last ? PH_CK : PH_LO;
`else
          if (nib_ready) phase_nxt = PH_LO;
`endif
        end
      end
`ifdef SER_CHECKSUM_EN
      PH_CK: begin
        nib_valid = 1'b1;
        nib_out   = checksum;
        if (nib_ready) phase_nxt = PH_LO;
      end
`endif
      default: phase_nxt = PH_LO;
    endcase
  end

  // Queue storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= byte_in;
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

`ifdef SER_CHECKSUM_EN
  // Running XOR of data nibbles and byte count within the current frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum  <= 4'h0;
      frame_cnt <= '0;
    end else if (xfer) begin
      if (phase == PH_CK) begin
        checksum  <= 4'h0;
        frame_cnt <= '0;
      end else begin
        checksum <= checksum ^ nib_out;
        if (phase == PH_HI) frame_cnt <= frame_cnt + FC_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serializer.sv
// Directed bench for nibble_serializer: table-driven cycle vectors plus
// hand-written streaming and reset sequences.
module tb_nibble_serializer;

`ifdef SER_CHECKSUM_EN
  localparam int unsigned TB_FRAME = 2;
`else
  localparam int unsigned TB_FRAME = 8;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic [3:0] nib_out;
  logic       nib_valid;
  logic       nib_ready;
  logic [2:0] level;

  nibble_serializer #(.BUF_DEPTH(4), .FRAME_LEN(TB_FRAME)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .nib_out    (nib_out),
    .nib_valid  (nib_valid),
    .nib_ready  (nib_ready),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       bv;
    logic [7:0] b;
    logic       nr;
    logic       e_br;
    logic       e_nv;
    logic [3:0] e_nib;
    logic [2:0] e_lvl;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] tx_bytes[32];
  logic [3:0] exp_nibs[64];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic bv, input logic [7:0] b, input logic nr,
                             input logic br, input logic nv, input logic [3:0] nib,
                             input logic [2:0] lvl);
    vec_t r;
    r.bv = bv; r.b = b; r.nr = nr;
    r.e_br = br; r.e_nv = nv; r.e_nib = nib; r.e_lvl = lvl;
    return r;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; byte_valid = 1'b0; nib_ready = 1'b0; byte_in = 8'h00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Each row: compare outputs of the current cycle, then drive inputs for the next edge
  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      chk($sformatf("%s[%0d] byte_ready", tag, i), 32'(byte_ready), 32'(tbl[i].e_br));
      chk($sformatf("%s[%0d] nib_valid", tag, i), 32'(nib_valid), 32'(tbl[i].e_nv));
      chk($sformatf("%s[%0d] level", tag, i), 32'(level), 32'(tbl[i].e_lvl));
      if (tbl[i].e_nv)
        chk($sformatf("%s[%0d] nib_out", tag, i), 32'(nib_out), 32'(tbl[i].e_nib));
      byte_valid = tbl[i].bv;
      byte_in    = tbl[i].b;
      nib_ready  = tbl[i].nr;
    end
    tbl.delete();
  endtask

  // Streams tx_bytes with both handshakes open and checks the nibble sequence
  task automatic stream_check(input int nbytes, input int nnibs, input string tag);
    int bi = 0;
    int ni = 0;
    int cyc = 0;
    nib_ready = 1'b1;
    while ((bi < nbytes || ni < nnibs) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (nib_valid) begin
        if (ni < nnibs)
          chk($sformatf("%s nib[%0d]", tag, ni), 32'(nib_out), 32'(exp_nibs[ni]));
        ni++;
      end
      if (bi < nbytes) begin
        byte_valid = 1'b1;
        byte_in    = tx_bytes[bi];
        if (byte_ready) bi++;
      end else begin
        byte_valid = 1'b0;
      end
    end
    chk($sformatf("%s bytes accepted", tag), 32'(bi), 32'(nbytes));
    chk($sformatf("%s nibbles seen", tag), 32'(ni), 32'(nnibs));
    byte_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s drained nib_valid", tag), 32'(nib_valid), 32'd0);
    chk($sformatf("%s drained level", tag), 32'(level), 32'd0);
    nib_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; byte_valid = 1'b0; byte_in = 8'h00; nib_ready = 1'b0;

    // T1: reset values, then reset mid-stream with 3 bytes queued
    #1;
    chk("reset nib_valid", 32'(nib_valid), 32'd0);
    chk("reset byte_ready", 32'(byte_ready), 32'd0);
    chk("reset level", 32'(level), 32'd0);
    chk("reset nib_out", 32'(nib_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset byte_ready", 32'(byte_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_in    = 8'(8'h40 + i);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    chk("T1 queued level", 32'(level), 32'd3);
    chk("T1 queued nib_valid", 32'(nib_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("T1 async level", 32'(level), 32'd0);
    chk("T1 async nib_valid", 32'(nib_valid), 32'd0);
    chk("T1 async byte_ready", 32'(byte_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("T1 release byte_ready", 32'(byte_ready), 32'd1);
    @(negedge clk);
    chk("T1 after edge level", 32'(level), 32'd0);
    chk("T1 after edge nib_valid", 32'(nib_valid), 32'd0);

    // T2: single byte 0xA5
    reset_dut();
    tbl.push_back(v(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 4'h0, 3'd0));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h5, 3'd1));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'hA, 3'd1));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0));
    run_table("T2");

    // T3: backpressure holds the low nibble
    reset_dut();
    tbl.push_back(v(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(v(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'hC, 3'd1));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'hC, 3'd1));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h3, 3'd1));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0));
    run_table("T3");

`ifndef SER_CHECKSUM_EN
    // T4: fill the queue; a pop while full does not admit the held byte
    reset_dut();
    tbl.push_back(v(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0));
    tbl.push_back(v(1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 4'h1, 3'd1));
    tbl.push_back(v(1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 4'h1, 3'd2));
    tbl.push_back(v(1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 4'h1, 3'd3));
    tbl.push_back(v(1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 4'h1, 3'd4));
    tbl.push_back(v(1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 4'h1, 3'd4));
    tbl.push_back(v(1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 4'h0, 3'd4));
    tbl.push_back(v(1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 4'h2, 3'd3));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 3'd4));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h3, 3'd3));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 3'd3));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h4, 3'd2));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 3'd2));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h5, 3'd1));
    tbl.push_back(v(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 4'h0, 3'd1));
    tbl.push_back(v(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'h0, 3'd0));
    run_table("T4");

    // T5: 16-byte stream with concurrent push/pop and pointer wrap
    reset_dut();
    for (int i = 0; i < 16; i++) begin
      tx_bytes[i]       = 8'(8'h10 + i);
      exp_nibs[2*i]     = 4'(i);
      exp_nibs[2*i + 1] = 4'h1;
    end
    stream_check(16, 32, "T5");
`else
    // T6: two checksum frames of two bytes each
    reset_dut();
    tx_bytes[0] = 8'h12; tx_bytes[1] = 8'h34; tx_bytes[2] = 8'h56; tx_bytes[3] = 8'h78;
    exp_nibs[0] = 4'h2; exp_nibs[1] = 4'h1; exp_nibs[2] = 4'h4; exp_nibs[3] = 4'h3;
    exp_nibs[4] = 4'h4;
    exp_nibs[5] = 4'h6; exp_nibs[6] = 4'h5; exp_nibs[7] = 4'h8; exp_nibs[8] = 4'h7;
    exp_nibs[9] = 4'hC;
    stream_check(4, 10, "T6");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
